// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage bitwise logic unit with valid/ready flow control.
// Optional zero/parity result flags are built when LOGIC_UNIT_FLAGS_EN is defined.
`timescale 1ns/1ps
module logic_unit_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    input  logic         in_acc,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic         out_zero,
    output logic         out_parity,
`endif
    output logic [W-1:0] out_data
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         acc;
    } s1_t;

    s1_t          s1_q;
    logic         s1_valid;
    logic         s2_load;
    logic         in_fire;
    logic         out_fire;
    logic [W-1:0] b_eff;
    logic [W-1:0] result;

    // Handshake: S2 frees when empty or draining; S1 frees when empty or moving on
    always_comb begin
        s2_load  = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_load;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Stage 1 operand register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= '{a: in_a, b: in_b, op: in_op, acc: in_acc};
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Operation decode; accumulate takes b from the held result register
    always_comb begin
        result = '0;
        b_eff  = s1_q.acc ? out_data : s1_q.b;
        unique case (s1_q.op)
            3'b000: result = s1_q.a & b_eff;
            3'b001: result = s1_q.a | b_eff;
            3'b010: result = ~(s1_q.a & b_eff);
            3'b011: result = ~(s1_q.a | b_eff);
            3'b100: result = s1_q.a ^ b_eff;
            3'b101: result = ~(s1_q.a ^ b_eff);
            3'b110: result = ~s1_q.a;
            3'b111: result = s1_q.a;
        endcase
    end

    // Stage 2 result register; data holds until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Result flags, registered alongside out_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero   <= 1'b1;
            out_parity <= 1'b0;
        end else if (s2_load) begin
            out_zero   <= (result == '0);
            out_parity <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe at W=8, W=1 and W=64.
// Flag checks are compiled in when LOGIC_UNIT_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // W=8 instance
    logic       v8 = 0, r8, acc8 = 0, ov8, ordy8 = 0;
    logic [7:0] a8 = 0, b8 = 0, d8;
    logic [2:0] op8 = 0;
    logic       zs8, ps8;
    logic [7:0] q8[$];
    logic [9:0] qf[$];
    logic [7:0] last8 = 0;

    // W=1 and W=64 instances, driven in lockstep
    logic        vw = 0, accw = 0, rw = 0;
    logic [63:0] aw = 0, bw = 0, d64;
    logic [2:0]  opw = 0;
    logic        rdy1, rdy64, ov1, ov64;
    logic [0:0]  d1;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic z8, p8, z1, p1, z64, p64;
`endif

    logic_unit_pipe #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .in_a(a8), .in_b(b8), .in_op(op8), .in_acc(acc8),
        .out_valid(ov8), .out_ready(ordy8),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero(z8), .out_parity(p8),
`endif
        .out_data(d8)
    );

    logic_unit_pipe #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vw), .in_ready(rdy1),
        .in_a(aw[0:0]), .in_b(bw[0:0]), .in_op(opw), .in_acc(accw),
        .out_valid(ov1), .out_ready(rw),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero(z1), .out_parity(p1),
`endif
        .out_data(d1)
    );

    logic_unit_pipe #(.W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(vw), .in_ready(rdy64),
        .in_a(aw), .in_b(bw), .in_op(opw), .in_acc(accw),
        .out_valid(ov64), .out_ready(rw),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero(z64), .out_parity(p64),
`endif
        .out_data(d64)
    );

    function automatic logic [63:0] ref_op(input logic [2:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // One W=8 cycle: drive at negedge, observe 1ns later, cross the posedge
    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc, input logic rdy,
                         output logic fin, output logic fout,
                         output logic ovs, output logic irs, output logic [7:0] d);
        v8 = v; a8 = a; b8 = b; op8 = op; acc8 = acc; ordy8 = rdy;
        #1;
        irs  = r8;
        ovs  = ov8;
        d    = d8;
        fin  = v && r8;
        fout = ov8 && rdy;
`ifdef LOGIC_UNIT_FLAGS_EN
        zs8 = z8;
        ps8 = p8;
`else
        zs8 = 1'b0;
        ps8 = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic fin, fout, ovs, irs;
        logic [7:0] d, e;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (r8 !== 1'b1 || ov8 !== 1'b0 || d8 !== 8'h00) begin
            fails++;
            $display("FAIL reset_idle: rdy=%b vld=%b data=%h, required 1 0 00", r8, ov8, d8);
        end
`ifdef LOGIC_UNIT_FLAGS_EN
        tests++;
        if (z8 !== 1'b1 || p8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: zero=%b par=%b, required 1 0", z8, p8);
        end
`endif
        rst = 1'b0;
        step8(1, 8'hFF, 8'h00, 3'd1, 0, 0, fin, fout, ovs, irs, d);
        step8(1, 8'h55, 8'h00, 3'd7, 0, 0, fin, fout, ovs, irs, d);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (r8 !== 1'b1 || ov8 !== 1'b0 || d8 !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b vld=%b data=%h, required 1 0 00", r8, ov8, d8);
        end
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        last8 = 8'h00;
        step8(1, 8'h12, 8'hAB, 3'd1, 1, 1, fin, fout, ovs, irs, d);
        tests++;
        if (fin !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_accept: fire=%b, required 1", fin);
        end
        q8.push_back(8'h12);
        last8 = 8'h12;
        step8(0, 8'h00, 8'h00, 3'd0, 0, 1, fin, fout, ovs, irs, d);
        tests++;
        if (ovs !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: out_valid=%b, required 0", ovs);
        end
        step8(0, 8'h00, 8'h00, 3'd0, 0, 1, fin, fout, ovs, irs, d);
        tests++;
        if (ovs !== 1'b1 || q8.size() == 0) begin
            fails++;
            $display("FAIL latency_valid: out_valid=%b, required 1", ovs);
        end else begin
            e = q8.pop_front();
            if (d !== e) begin
                fails++;
                $display("FAIL latency_result: got %h, required %h", d, e);
            end
        end
    endtask

    task automatic test_op_sweep;
        logic fin, fout, ovs, irs;
        logic [7:0] d, e;
        logic [7:0] exp_tab [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00,
                                    8'hFF, 8'h00, 8'h3A, 8'hC5};
        int got = 0;
        for (int i = 0; i < 18 && (i < 8 || q8.size() > 0); i++) begin
            step8(i < 8, 8'hC5, 8'h3A, 3'(i), 0, 1, fin, fout, ovs, irs, d);
            if (i < 8) begin
                tests++;
                if (fin !== 1'b1) begin
                    fails++;
                    $display("FAIL sweep_accept%0d: fire=%b, required 1", i, fin);
                end
                q8.push_back(exp_tab[i]);
                last8 = exp_tab[i];
            end
            if (fout) begin
                tests++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL sweep_extra: got %h, required no output", d);
                end else begin
                    e = q8.pop_front();
                    got++;
                    if (d !== e) begin
                        fails++;
                        $display("FAIL sweep_op%0d: got %h, required %h", got - 1, d, e);
                    end
                end
            end
        end
        tests++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL sweep_drain: %0d results missing, required 0", q8.size());
        end
    endtask

    task automatic test_accumulate;
        logic fin, fout, ovs, irs;
        logic [7:0] d, e;
        logic [7:0] ta [3] = '{8'h0F, 8'h3C, 8'hFF};
        logic [7:0] tb [3] = '{8'hF0, 8'h99, 8'h66};
        logic [2:0] to [3] = '{3'd1, 3'd4, 3'd0};
        logic       tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] te [3] = '{8'hFF, 8'hC3, 8'hC3};
        for (int i = 0; i < 14 && (i < 3 || q8.size() > 0); i++) begin
            if (i < 3) step8(1, ta[i], tb[i], to[i], tc[i], 1, fin, fout, ovs, irs, d);
            else       step8(0, 8'h00, 8'h00, 3'd0, 0, 1, fin, fout, ovs, irs, d);
            if (fin) begin
                q8.push_back(te[i]);
                last8 = te[i];
            end
            if (fout) begin
                tests++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL acc_extra: got %h, required no output", d);
                end else begin
                    e = q8.pop_front();
                    if (d !== e) begin
                        fails++;
                        $display("FAIL acc_chain: got %h, required %h", d, e);
                    end
                end
            end
        end
        tests++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL acc_drain: %0d results missing, required 0", q8.size());
        end
    endtask

    task automatic test_backpressure;
        logic fin, fout, ovs, irs;
        logic [7:0] d, e, exp;
        logic [7:0] ta [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [2:0] to [4] = '{3'd4, 3'd1, 3'd0, 3'd5};
        int k = 0;
        int idx;
        for (int c = 0; c < 4; c++) begin
            step8(1, ta[k], 8'h0F, to[k], 0, 0, fin, fout, ovs, irs, d);
            if (fin) begin
                exp = ref_op(to[k], {56'h0, ta[k]}, 64'h0F);
                q8.push_back(exp);
                last8 = exp;
                k++;
            end
            if (ovs) begin
                tests++;
                if (d !== q8[0]) begin
                    fails++;
                    $display("FAIL bp_hold: got %h, required %h", d, q8[0]);
                end
            end
        end
        tests++;
        if (k != 2 || irs !== 1'b0) begin
            fails++;
            $display("FAIL bp_absorb: accepted %0d ready=%b, required 2 0", k, irs);
        end
        for (int c = 0; c < 30 && (k < 4 || q8.size() > 0); c++) begin
            idx = (k < 4) ? k : 0;
            step8(k < 4, ta[idx], 8'h0F, to[idx], 0, 1, fin, fout, ovs, irs, d);
            if (fin) begin
                exp = ref_op(to[idx], {56'h0, ta[idx]}, 64'h0F);
                q8.push_back(exp);
                last8 = exp;
                k++;
            end
            if (fout) begin
                tests++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: got %h, required no output", d);
                end else begin
                    e = q8.pop_front();
                    if (d !== e) begin
                        fails++;
                        $display("FAIL bp_order: got %h, required %h", d, e);
                    end
                end
            end
        end
        tests++;
        if (k != 4 || q8.size() != 0) begin
            fails++;
            $display("FAIL bp_drain: accepted %0d pending %0d, required 4 0", k, q8.size());
        end
    endtask

    task automatic test_flags;
`ifdef LOGIC_UNIT_FLAGS_EN
        logic fin, fout, ovs, irs;
        logic [7:0] d;
        logic [9:0] e;
        logic [7:0] ta [2] = '{8'hAA, 8'h07};
        logic [2:0] to [2] = '{3'd4, 3'd7};
        logic [9:0] te [2] = '{{1'b1, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h07}};
        for (int i = 0; i < 12 && (i < 2 || qf.size() > 0); i++) begin
            if (i < 2) step8(1, ta[i], 8'hAA, to[i], 0, 1, fin, fout, ovs, irs, d);
            else       step8(0, 8'h00, 8'h00, 3'd0, 0, 1, fin, fout, ovs, irs, d);
            if (fin) begin
                qf.push_back(te[i]);
                last8 = te[i][7:0];
            end
            if (fout) begin
                tests++;
                if (qf.size() == 0) begin
                    fails++;
                    $display("FAIL flags_extra: got %h, required no output", d);
                end else begin
                    e = qf.pop_front();
                    if ({zs8, ps8, d} !== e) begin
                        fails++;
                        $display("FAIL flags: got z=%b p=%b d=%h, required z=%b p=%b d=%h",
                                 zs8, ps8, d, e[9], e[8], e[7:0]);
                    end
                end
            end
        end
        tests++;
        if (qf.size() != 0) begin
            fails++;
            $display("FAIL flags_drain: %0d results missing, required 0", qf.size());
        end
`endif
    endtask

    task automatic test_width_corner;
        logic [63:0] q64[$];
        logic        q1[$];
        logic [63:0] last64 = 64'h0;
        logic [63:0] t, e64;
        logic        last1 = 1'b0;
        logic        e1;
        int          sent = 0;
        for (int c = 0; c < 8000 && (sent < 1000 || q64.size() > 0 || q1.size() > 0); c++) begin
            vw   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rw   = ($urandom_range(0, 3) != 0);
            opw  = 3'($urandom_range(0, 7));
            accw = ($urandom_range(0, 3) == 0);
            aw   = {$urandom, $urandom};
            bw   = {$urandom, $urandom};
            #1;
            if (vw && rdy64) begin
                e64 = ref_op(opw, aw, accw ? last64 : bw);
                q64.push_back(e64);
                last64 = e64;
                sent++;
            end
            if (vw && rdy1) begin
                t = ref_op(opw, {63'h0, aw[0]}, {63'h0, accw ? last1 : bw[0]});
                q1.push_back(t[0]);
                last1 = t[0];
            end
            if (ov64 && rw) begin
                tests++;
                if (q64.size() == 0) begin
                    fails++;
                    $display("FAIL w64_extra: got %h, required no output", d64);
                end else begin
                    e64 = q64.pop_front();
                    if (d64 !== e64) begin
                        fails++;
                        $display("FAIL w64_result: got %h, required %h", d64, e64);
                    end
                end
            end
            if (ov1 && rw) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL w1_extra: got %b, required no output", d1);
                end else begin
                    e1 = q1.pop_front();
                    if (d1[0] !== e1) begin
                        fails++;
                        $display("FAIL w1_result: got %b, required %b", d1, e1);
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        vw = 1'b0;
        tests++;
        if (sent != 1000 || q64.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL width_drain: sent %0d pending %0d/%0d, required 1000 0/0",
                     sent, q64.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_accumulate();
        test_backpressure();
        test_flags();
        test_width_corner();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
